// File: rtl/useq_pkg.sv
// useq_pkg: shared definitions for the microsequencer slice.
//   - useq_mode_e : sequencing mode codes held in the control word.
//   - field width constants and offset helpers. The offsets are functions of
//     ADDR_W/CNT_W so that every parameterisation shares one layout rule.
//   - condition-code bit indices inside cc = {Z,N,C,V}.
package useq_pkg;

  typedef enum logic [2:0] {
    MODE_SEQ    = 3'd0,
    MODE_JUMP   = 3'd1,
    MODE_DISP_I = 3'd2,
    MODE_DISP_S = 3'd3,
    MODE_BRCOND = 3'd4,
    MODE_CALL   = 3'd5,
    MODE_RET    = 3'd6,
    MODE_LOOP   = 3'd7
  } useq_mode_e;

  localparam int MODE_W = 3;
  localparam int CSEL_W = 2;
  localparam int CPOL_W = 1;

  localparam int CC_Z = 3;
  localparam int CC_N = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

  // Control word layout, LSB first: db | mode | csel | cpol | lcnt | eu.
  function automatic int mode_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int csel_lsb(input int addr_w);
    return addr_w + MODE_W;
  endfunction

  function automatic int cpol_lsb(input int addr_w);
    return addr_w + MODE_W + CSEL_W;
  endfunction

  function automatic int lcnt_lsb(input int addr_w);
    return addr_w + MODE_W + CSEL_W + CPOL_W;
  endfunction

  function automatic int eu_lsb(input int addr_w, input int cnt_w);
    return lcnt_lsb(addr_w) + cnt_w;
  endfunction

  function automatic int cw_width(input int addr_w, input int eu_w, input int cnt_w);
    return eu_lsb(addr_w, cnt_w) + eu_w;
  endfunction

endpackage

// File: rtl/microsequencer_ustack.sv
// ustack: DEPTH x WIDTH return-address LIFO for micro-subroutines.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset (clears sp)
//   push, pop    : stack operations; push ignored when full, pop when empty
//   din          : value pushed
//   top          : most recently pushed entry (undefined when empty)
//   sp           : occupancy 0..DEPTH
//   full, empty  : occupancy flags
module ustack
  import useq_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 5,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [SP_W-1:0]  sp,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [SP_W-1:0]  sp_r;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (sp_r == SP_W'(DEPTH));
  assign empty     = (sp_r == {SP_W{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // DEPTH is a power of two, so the low bits of sp address the next free
  // slot; when full they wrap to 0 and rd_idx wraps to DEPTH-1 as needed.
  assign wr_idx_s = sp_r[IDX_W-1:0];
  assign rd_idx_s = wr_idx_s - IDX_W'(1);
  assign top      = mem_r[rd_idx_s];
  assign sp       = sp_r;

  // Occupancy counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_r <= {SP_W{1'b0}};
    end else if (do_push_s) begin
      sp_r <= sp_r + SP_W'(1);
    end else if (do_pop_s) begin
      sp_r <= sp_r - SP_W'(1);
    end
  end

  // Entry storage; contents need no reset because sp gates every read.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_idx_s] <= din;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer: next micro-address generator plus control-word register.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   rom_addr     : combinational address presented to the control ROM
//   rom_data     : control word read combinationally at rom_addr
//   ib, sb       : primary/secondary dispatch addresses from the decoder
//   cc           : condition codes {Z,N,C,V}
//   stall        : freezes every register and suppresses stack/counter updates
//   eucntl       : EU field of the registered control word
//   eucntl_valid : eucntl is to be executed this cycle (not stalled)
//   fault        : sticky stack overflow/underflow indication
//   sp           : return stack occupancy
module microsequencer
  import useq_pkg::*;
#(
  parameter  int ADDR_W      = 5,
  parameter  int EU_W        = 18,
  parameter  int CNT_W       = 4,
  parameter  int STACK_DEPTH = 4,
  localparam int CW_W        = cw_width(ADDR_W, EU_W, CNT_W),
  localparam int SP_W        = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CW_W-1:0]   rom_data,
  input  logic [ADDR_W-1:0] ib,
  input  logic [ADDR_W-1:0] sb,
  input  logic [3:0]        cc,
  input  logic              stall,
  output logic [EU_W-1:0]   eucntl,
  output logic              eucntl_valid,
  output logic              fault,
  output logic [SP_W-1:0]   sp
);

  localparam int MODE_LSB = mode_lsb(ADDR_W);
  localparam int CSEL_LSB = csel_lsb(ADDR_W);
  localparam int CPOL_LSB = cpol_lsb(ADDR_W);
  localparam int LCNT_LSB = lcnt_lsb(ADDR_W);
  localparam int EU_LSB   = eu_lsb(ADDR_W, CNT_W);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  // Architectural state.
  logic [CW_W-1:0]   cw_r;
  logic [ADDR_W-1:0] upc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              fault_r;

  // Decoded fields of the current control word.
  logic [ADDR_W-1:0] db_s;
  useq_mode_e        mode_s;
  logic [1:0]        csel_s;
  logic              cpol_s;
  logic [CNT_W-1:0]  lcnt_s;

  logic [ADDR_W-1:0] seq_s;
  logic              cond_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] rom_addr_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              push_req_s;
  logic              pop_req_s;
  logic              fault_set_s;
  logic              push_s;
  logic              pop_s;

  logic [ADDR_W-1:0] stk_top_s;
  logic              stk_full_s;
  logic              stk_empty_s;

  assign db_s   = cw_r[ADDR_W-1:0];
  assign mode_s = useq_mode_e'(cw_r[MODE_LSB +: MODE_W]);
  assign csel_s = cw_r[CSEL_LSB +: CSEL_W];
  assign cpol_s = cw_r[CPOL_LSB];
  assign lcnt_s = cw_r[LCNT_LSB +: CNT_W];

  assign seq_s  = upc_r + ADDR_W'(1);
  assign cond_s = cc[csel_s] ^ cpol_s;

  // Next-address selection and stack/fault requests for the current word.
  always_comb begin
    addr_s      = seq_s;
    push_req_s  = 1'b0;
    pop_req_s   = 1'b0;
    fault_set_s = 1'b0;
    case (mode_s)
      MODE_SEQ:    addr_s = seq_s;
      MODE_JUMP:   addr_s = db_s;
      MODE_DISP_I: addr_s = ib;
      MODE_DISP_S: addr_s = sb;
      MODE_BRCOND: begin
        if (cond_s) begin
          addr_s = db_s;
        end else begin
          addr_s = seq_s;
        end
      end
      MODE_CALL: begin
        // Overflow still takes the jump; only the push is lost.
        addr_s = db_s;
        if (stk_full_s) begin
          fault_set_s = 1'b1;
        end else begin
          push_req_s = 1'b1;
        end
      end
      MODE_RET: begin
        // Underflow restarts microcode at address 0.
        if (stk_empty_s) begin
          addr_s      = ADDR_ZERO;
          fault_set_s = 1'b1;
        end else begin
          addr_s    = stk_top_s;
          pop_req_s = 1'b1;
        end
      end
      MODE_LOOP: begin
        if (cnt_r != CNT_ZERO) begin
          addr_s = db_s;
        end else begin
          addr_s = seq_s;
        end
      end
      default: addr_s = seq_s;
    endcase
  end

  // Loop counter: LOOP decrements towards zero; any other word with a
  // non-zero lcnt field preloads the counter.
  always_comb begin
    cnt_next_s = cnt_r;
    if (mode_s == MODE_LOOP) begin
      if (cnt_r != CNT_ZERO) begin
        cnt_next_s = cnt_r - CNT_W'(1);
      end else begin
        cnt_next_s = cnt_r;
      end
    end else if (lcnt_s != CNT_ZERO) begin
      cnt_next_s = lcnt_s;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Reset forces the ROM address to 0 so word 0 is fetched on the first
  // edge after reset is released.
  always_comb begin
    if (reset) begin
      rom_addr_s = ADDR_ZERO;
    end else begin
      rom_addr_s = addr_s;
    end
  end

  assign push_s = push_req_s & ~stall & ~reset;
  assign pop_s  = pop_req_s & ~stall & ~reset;

  // Control word, micro-PC, loop counter and sticky fault; stall holds all.
  always_ff @(posedge clock) begin
    if (reset) begin
      cw_r    <= {CW_W{1'b0}};
      upc_r   <= {ADDR_W{1'b1}};
      cnt_r   <= CNT_ZERO;
      fault_r <= 1'b0;
    end else if (!stall) begin
      cw_r    <= rom_data;
      upc_r   <= rom_addr_s;
      cnt_r   <= cnt_next_s;
      fault_r <= fault_r | fault_set_s;
    end
  end

  ustack #(
    .DEPTH(STACK_DEPTH),
    .WIDTH(ADDR_W)
  ) u_stack (
    .clock(clock),
    .reset(reset),
    .push (push_s),
    .pop  (pop_s),
    .din  (seq_s),
    .top  (stk_top_s),
    .sp   (sp),
    .full (stk_full_s),
    .empty(stk_empty_s)
  );

  assign rom_addr     = rom_addr_s;
  assign eucntl       = cw_r[EU_LSB +: EU_W];
  assign eucntl_valid = ~stall;
  assign fault        = fault_r;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus randomized
// programs, all checked against a queue-based behavioural model.
module tb_microsequencer;

  localparam int ADDR_W = 5;
  localparam int EU_W   = 18;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 4;
  localparam int CW_W   = 33;
  localparam int SP_W   = 3;
  localparam int NWORDS = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              stall;
  logic [ADDR_W-1:0] rom_addr;
  logic [CW_W-1:0]   rom_data;
  logic [ADDR_W-1:0] ib;
  logic [ADDR_W-1:0] sb;
  logic [3:0]        cc;
  logic [EU_W-1:0]   eucntl;
  logic              eucntl_valid;
  logic              fault;
  logic [SP_W-1:0]   sp;

  logic [CW_W-1:0] rom [NWORDS];
  assign rom_data = rom[rom_addr];

  always #5 clock = ~clock;

  microsequencer #(
    .ADDR_W(ADDR_W), .EU_W(EU_W), .CNT_W(CNT_W), .STACK_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .ib(ib), .sb(sb), .cc(cc), .stall(stall), .eucntl(eucntl),
    .eucntl_valid(eucntl_valid), .fault(fault), .sp(sp)
  );

  // Behavioural model state.
  logic [63:0] m_cw;
  int          m_upc;
  int          m_cnt;
  int          m_fault;
  int          m_stack[$];
  int          m_next;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_loop[13]  = '{0, 1, 2, 3, 4, 5, 4, 5, 4, 5, 4, 5, 6};
  int exp_call[7]   = '{0, 1, 10, 20, 11, 2, 3};
  int exp_csp[7]    = '{0, 0, 0, 1, 2, 1, 0};
  int exp_stall[16] = '{0, 1, 2, 3, 4, 5, 4, 5, 4, 4, 4, 4, 5, 4, 5, 6};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int fld(input logic [63:0] w, input int lsb, input int width);
    logic [63:0] t;
    t = w >> lsb;
    return int'(t % (64'd1 << width));
  endfunction

  function automatic logic [CW_W-1:0] mk(input int mode, input int db, input int csel,
                                         input int cpol, input int lcnt);
    logic [CW_W-1:0] w;
    w = {EU_W'($urandom), CNT_W'(lcnt), 1'(cpol), 2'(csel), 3'(mode), ADDR_W'(db)};
    return w;
  endfunction

  function automatic void fill_seq();
    for (int k = 0; k < NWORDS; k++) rom[k] = mk(0, $urandom_range(0, 31), 0, 0, 0);
  endfunction

  // Address the model expects the sequencer to present for the current word.
  function automatic int model_next();
    int db   = fld(m_cw, 0, 5);
    int mode = fld(m_cw, 5, 3);
    int csel = fld(m_cw, 8, 2);
    int cpol = fld(m_cw, 10, 1);
    int seq  = (m_upc + 1) % NWORDS;
    case (mode)
      0: return seq;
      1: return db;
      2: return int'(ib);
      3: return int'(sb);
      4: return (int'(cc[csel]) != cpol) ? db : seq;
      5: return db;
      6: return (m_stack.size() == 0) ? 0 : m_stack[$];
      default: return (m_cnt != 0) ? db : seq;
    endcase
  endfunction

  // Model update for one non-stalled clock edge.
  task automatic model_edge();
    int nxt  = model_next();
    int mode = fld(m_cw, 5, 3);
    int lcnt = fld(m_cw, 11, 4);
    int seq  = (m_upc + 1) % NWORDS;
    if (mode == 5) begin
      if (m_stack.size() == DEPTH) m_fault = 1;
      else m_stack.push_back(seq);
    end
    if (mode == 6) begin
      if (m_stack.size() == 0) m_fault = 1;
      else void'(m_stack.pop_back());
    end
    if (mode == 7) begin
      if (m_cnt != 0) m_cnt = m_cnt - 1;
    end else if (lcnt != 0) begin
      m_cnt = lcnt;
    end
    m_upc = nxt;
    m_cw  = 64'(rom[nxt]);
  endtask

  task automatic drive(input logic st, input logic [3:0] c);
    stall = st;
    cc    = c;
    ib    = ADDR_W'($urandom);
    sb    = ADDR_W'($urandom);
    #1;
    m_next = model_next();
    check_val("rom_addr", 64'(rom_addr), 64'(m_next));
    check_val("eucntl", 64'(eucntl), 64'(fld(m_cw, 15, 18)));
    check_val("eucntl_valid", 64'(eucntl_valid), 64'(!st));
    check_val("sp", 64'(sp), 64'(m_stack.size()));
    check_val("fault", 64'(fault), 64'(m_fault));
  endtask

  task automatic tick();
    @(posedge clock);
    if (!stall) model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset(input logic st);
    reset = 1'b1;
    stall = st;
    cc    = 4'($urandom);
    #1;
    check_val("rst_rom_addr", 64'(rom_addr), 64'd0);
    @(posedge clock);
    m_cw    = 64'd0;
    m_upc   = NWORDS - 1;
    m_cnt   = 0;
    m_fault = 0;
    m_stack.delete();
    @(negedge clock);
    #1;
    check_val("rst_rom_addr_held", 64'(rom_addr), 64'd0);
    check_val("rst_eucntl", 64'(eucntl), 64'd0);
    check_val("rst_fault", 64'(fault), 64'd0);
    check_val("rst_sp", 64'(sp), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; cc = 4'd0; ib = '0; sb = '0;
    fill_seq();
    @(negedge clock);

    // All-SEQ program: addresses count up and wrap.
    do_reset(1'b0);
    for (int i = 0; i < 34; i++) begin
      drive(1'b0, 4'($urandom));
      check_val("wrap", 64'(rom_addr), 64'(i % NWORDS));
      tick();
    end

    // BRCOND on Z with both polarities and both Z values.
    for (int k = 0; k < 4; k++) begin
      fill_seq();
      rom[3] = mk(4, 20, 3, k / 2, 0);
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) begin drive(1'b0, 4'($urandom)); tick(); end
      drive(1'b0, (k % 2 == 1) ? 4'b1000 : 4'b0000);
      check_val("brcond", 64'(rom_addr), ((k % 2) != (k / 2)) ? 64'd20 : 64'd4);
      tick();
    end

    // Counted loop.
    fill_seq();
    rom[2] = mk(0, 9, 0, 0, 3);
    rom[5] = mk(7, 4, 0, 0, 0);
    do_reset(1'b0);
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, 4'($urandom));
      check_val("loop_trace", 64'(rom_addr), 64'(exp_loop[i]));
      tick();
    end

    // Nested call/return.
    fill_seq();
    rom[1]  = mk(5, 10, 0, 0, 0);
    rom[10] = mk(5, 20, 0, 0, 0);
    rom[20] = mk(6, 0, 0, 0, 0);
    rom[11] = mk(6, 0, 0, 0, 0);
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 4'($urandom));
      check_val("call_trace", 64'(rom_addr), 64'(exp_call[i]));
      check_val("call_sp", 64'(sp), 64'(exp_csp[i]));
      tick();
    end

    // Five nested calls overflow a four-deep stack.
    fill_seq();
    for (int k = 0; k < 5; k++) rom[k] = mk(5, k + 1, 0, 0, 0);
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin drive(1'b0, 4'($urandom)); tick(); end
    drive(1'b0, 4'($urandom));
    check_val("ovf_fault", 64'(fault), 64'd1);
    check_val("ovf_sp", 64'(sp), 64'd4);
    tick();

    // Return with empty stack restarts at 0; fault sticks until reset.
    fill_seq();
    rom[7] = mk(6, 0, 0, 0, 0);
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin drive(1'b0, 4'($urandom)); tick(); end
    drive(1'b0, 4'($urandom));
    check_val("ret_restart", 64'(rom_addr), 64'd0);
    tick();
    for (int i = 0; i < 12; i++) begin drive(1'b0, 4'($urandom)); tick(); end
    drive(1'b0, 4'($urandom));
    check_val("fault_sticky", 64'(fault), 64'd1);
    do_reset(1'b1);

    // Stall for three cycles in the middle of a loop.
    fill_seq();
    rom[2] = mk(0, 9, 0, 0, 3);
    rom[5] = mk(7, 4, 0, 0, 0);
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      drive((i >= 8 && i <= 10), 4'($urandom));
      check_val("stall_trace", 64'(rom_addr), 64'(exp_stall[i]));
      tick();
    end

    // Random programs with random stalls, flags, dispatch and resets.
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < NWORDS; k++)
        rom[k] = mk($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(0, 15));
      do_reset(1'($urandom_range(0, 1)));
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 59) == 0) begin
          do_reset(1'($urandom_range(0, 1)));
        end else begin
          drive(($urandom_range(0, 4) == 0), 4'($urandom));
          tick();
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Parametrised successor to the microprogram next-state logic plus control-store output register.
- Generates the control-ROM address each cycle and registers the fetched control word for the execution unit.
- Beyond jump and dispatch, it adds: conditional branch on any of the four flags with selectable polarity, micro-subroutine call/return via a hardware stack, a loop counter, a stall input, and a sticky fault flag.
- Sits between the instruction decoder (ib, sb), the execution unit (cc) and an external combinational control ROM.

Parameters:
- ADDR_W, 5, micro-address width; ROM holds 2^ADDR_W words.
- EU_W, 18, width of execution-unit control field passed through.
- CNT_W, 4, loop counter width.
- STACK_DEPTH, 4, return-address stack entries (power of 2, ≥2).
- CW_W = EU_W+ADDR_W+6+CNT_W; derived constant, default 33; not overridable.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_W  combinational next micro-address to the control ROM.
- rom_data  in  CW_W  control word read combinationally from rom_addr.
- ib  in  ADDR_W  instruction dispatch address from decoder.
- sb  in  ADDR_W  secondary dispatch address from decoder.
- cc  in  4  condition codes {Z,N,C,V} (cc[3]=Z … cc[0]=V).
- stall  in  1  freeze sequencer.
- eucntl  out  EU_W  EU field of registered control word.
- eucntl_valid  out  1  high when eucntl should execute this cycle (= !stall).
- fault  out  1  sticky stack overflow/underflow flag.
- sp  out  clog2(STACK_DEPTH)+1  stack occupancy.

Behaviour:
- Control word fields, LSB first:
  - db[ADDR_W-1:0]: target address.
  - mode[2:0].
  - csel[1:0]: selects cc bit.
  - cpol[0]: invert condition.
  - lcnt[CNT_W-1:0].
  - eu[EU_W-1:0].
- Registers:
  - cw_q (control word).
  - upc_q (address of cw_q).
  - cnt_q (loop counter).
  - stack with sp_q.
  - fault_q.
- Each non-stalled rising edge: cw_q <= rom_data; upc_q <= rom_addr.
- rom_addr is computed combinationally from cw_q, upc_q, ib, sb, cc, cnt_q, sp_q. seq = (upc_q+1) mod 2^ADDR_W. cond = cc[csel] ^ cpol.
- Modes:
  - 000 SEQ: seq.
  - 001 JUMP: db.
  - 010 DISP_I: ib.
  - 011 DISP_S: sb.
  - 100 BRCOND: cond ? db : seq.
  - 101 CALL: push seq, go db.
  - 110 RET: pop top, go there.
  - 111 LOOP: if cnt_q≠0 then cnt_q<=cnt_q-1, go db; else go seq.
- Counter load: if mode≠LOOP and lcnt≠0, cnt_q<=lcnt on the same edge. LOOP ignores lcnt.
- Stack overflow (CALL with sp_q=STACK_DEPTH): no push, fault_q<=1, jump to db still taken.
- Stack underflow (RET with sp_q=0): fault_q<=1, rom_addr=0 (microcode restart).
- fault_q is sticky until reset.
- Stall: all registers hold, including cw_q, upc_q, cnt_q, stack and fault. rom_addr stays stable. eucntl_valid=0. Pushes, pops and counter decrements are suppressed while stall=1.
- Reset, at the edge with reset=1:
  - cw_q<=0 (mode SEQ).
  - upc_q<=all ones.
  - cnt_q<=0, sp_q<=0, fault_q<=0.
  - Stack contents are don't-care.
  - Reset overrides stall.
- Result of reset: rom_addr=0 during and after reset. The first post-reset edge fetches word 0. eucntl=0 during reset.
- Latency: a word fetched at edge n drives eucntl in cycle n and determines rom_addr for edge n+1 (single-cycle sequencing, no bubbles).
- Reset mid-loop or mid-subroutine discards counter and stack.

Decomposition:
- Package useq_pkg holds:
  - mode codes (SEQ…LOOP).
  - field offset/width constants derived from ADDR_W, CNT_W, EU_W.
  - cc bit index constants Z=3, N=2, C=1, V=0.
- One sub-module: ustack, a STACK_DEPTH×ADDR_W LIFO with push, pop, top, sp, full and empty outputs. It ignores push when full and pop when empty. Overflow/underflow faults are reported by microsequencer.

Test Plan:
- Reset, ROM word k = SEQ for all k → rom_addr sequence 0,1,2,…,31,0 (wrap); eucntl tracks ROM EU field of the previous address.
- Word 3 = BRCOND csel=3 (Z), cpol=0, db=20:
  - cc=4'b1000 → next fetch address 20.
  - cc=4'b0000 → 4.
  - Repeat with cpol=1 → results inverted.
- Word 2 = SEQ lcnt=3, word 5 = LOOP db=4, word 4 = SEQ → address trace 2,3,4,5,4,5,4,5,4,5,6; cnt_q ends at 0.
- Nested CALLs:
  - Word 1 CALL db=10, word 10 CALL db=20, words 20 and 11 are RET → trace 1,10,20,11,2; sp 0→1→2→1→0.
  - Five nested CALLs with STACK_DEPTH=4 → fault=1 after the 5th; sp stays 4.
- RET with sp=0 at address 7 → next rom_addr=0, fault=1, stays 1 until reset.
- stall=1 for 3 cycles during a LOOP with cnt_q=2:
  - rom_addr, cnt_q and sp unchanged; eucntl_valid=0.
  - After stall drops, the loop completes exactly 2 more iterations.
  - reset asserted with stall=1 → rom_addr=0, fault=0.
